stream_demux4: RTL and testbench

- Routes one valid/ready input stream to one of four output streams. This is the 1:4 steering counterpart to the 4:1 select path already in the design.
- The route is taken from `s_sel` on the first beat of each packet. It is held until the beat carrying `s_last`.
- Each output has a one-beat registered slot that runs at full throughput.
- Saturating per-output packet counters are provided for status and coverage.

---
 rtl/stream_demux4.sv | 119 +++++++++++
 tb/tb_stream_demux4.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// stream_demux4: steers one valid/ready stream to one of four output ports.
// The destination is latched from s_sel on a packet's first beat and held
// until the beat carrying s_last. Each port owns a one-beat registered slot
// that supports simultaneous load and drain, so a port with m_ready held
// high sustains one beat per cycle. Per-port saturating counters count
// completed output packets.
module stream_demux4 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  input  logic [1:0]          s_sel,
  output logic [3:0]          m_valid,
  input  logic [3:0]          m_ready,
  output logic [4*DATA_W-1:0] m_data,
  output logic [3:0]          m_last,
  input  logic                cnt_clr,
  output logic [4*CNT_W-1:0]  pkt_cnt,
  output logic                in_pkt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        route_q, route_d;
  logic [1:0]        route;
  logic [3:0]        slot_rdy;
  logic              accept;

  logic [3:0]        valid_q;
  logic [3:0]        last_q;
  logic [DATA_W-1:0] data_q [4];
  logic [CNT_W-1:0]  cnt_q  [4];

  // A packet start takes its destination straight from s_sel; later beats
  // use the locked destination and ignore s_sel.
  assign route    = (state_q == IN_PKT) ? route_q : s_sel;
  assign slot_rdy = ~valid_q | m_ready;
  // Held low during reset so no beat can be accepted into a slot being cleared.
  assign s_ready  = !rst && slot_rdy[route];
  assign accept   = s_valid && s_ready;

  assign m_valid  = valid_q;
  assign m_last   = last_q;
  assign in_pkt   = (state_q == IN_PKT);

  // Next-state logic for the packet lock.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      if (state_q == IDLE) begin
        if (!s_last) begin
          state_d = IN_PKT;
          route_d = s_sel;
        end
      end else if (s_last) begin
        state_d = IDLE;
      end
    end
  end

  // Packet-lock state and locked destination registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 2'd0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      logic load;
      logic drain;

      assign load  = accept && (route == 2'(gi));
      assign drain = valid_q[gi] && m_ready[gi];

      assign m_data[gi*DATA_W +: DATA_W] = data_q[gi];
      assign pkt_cnt[gi*CNT_W +: CNT_W]  = cnt_q[gi];

      // Output slot: a load always wins, so load+drain keeps the slot full.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          last_q[gi]  <= 1'b0;
          data_q[gi]  <= '0;
        end else if (load) begin
          valid_q[gi] <= 1'b1;
          last_q[gi]  <= s_last;
          data_q[gi]  <= s_data;
        end else if (drain) begin
          valid_q[gi] <= 1'b0;
        end
      end

      // Completed-packet counter; clear dominates, then saturating increment.
      always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
          cnt_q[gi] <= '0;
        end else if (drain && last_q[gi] && (cnt_q[gi] != CNT_MAX)) begin
          cnt_q[gi] <= cnt_q[gi] + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux4.sv
// Bench for stream_demux4: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_stream_demux4;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int SAT    = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic                s_last;
  logic [1:0]          s_sel;
  logic [3:0]          m_valid;
  logic [3:0]          m_ready;
  logic [4*DATA_W-1:0] m_data;
  logic [3:0]          m_last;
  logic                cnt_clr;
  logic [4*CNT_W-1:0]  pkt_cnt;
  logic                in_pkt;

  stream_demux4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_sel(s_sel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .cnt_clr(cnt_clr), .pkt_cnt(pkt_cnt), .in_pkt(in_pkt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: each port holds a queue of beats waiting downstream; a packet
  // in flight remembers its destination.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t mq [4][$];
  int    mcnt [4];
  bit    m_open;
  int    m_dest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cur_dest();
    return m_open ? m_dest : int'(s_sel);
  endfunction

  function automatic bit exp_ready();
    int d;
    d = cur_dest();
    return !rst && (mq[d].size() == 0 || m_ready[d]);
  endfunction

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_edge();
    bit    acc;
    int    d;
    beat_t b;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        mcnt[k] = 0;
      end
      m_open = 1'b0;
      m_dest = 0;
      return;
    end
    d   = cur_dest();
    acc = s_valid && exp_ready();
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0 && m_ready[k]) begin
        b = mq[k].pop_front();
        if (b.l && mcnt[k] < SAT) mcnt[k]++;
      end
      if (cnt_clr) mcnt[k] = 0;
    end
    if (acc) begin
      b.d = s_data;
      b.l = s_last;
      mq[d].push_back(b);
      if (!m_open && !s_last) begin
        m_open = 1'b1;
        m_dest = d;
      end else if (m_open && s_last) begin
        m_open = 1'b0;
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("m_valid", 32'(m_valid[k]), 32'(mq[k].size() != 0));
        if (mq[k].size() != 0) begin
          chk("m_data", 32'(m_data[k*DATA_W +: DATA_W]), 32'(mq[k][0].d));
          chk("m_last", 32'(m_last[k]), 32'(mq[k][0].l));
        end
        chk("pkt_cnt", 32'(pkt_cnt[k*CNT_W +: CNT_W]), 32'(mcnt[k]));
      end
      chk("in_pkt", 32'(in_pkt), 32'(m_open));
      chk("s_ready", 32'(s_ready), 32'(exp_ready()));
    end
  end

  // One clock: DUT and model both consume the current inputs, then #1.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [7:0] d, input bit l);
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
    s_last  = l;
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    s_valid = 1'b0;
    step();
    cnt_clr = 1'b0;
  endtask

  function automatic logic [7:0] port_data(input int k);
    return m_data[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [3:0] port_cnt(input int k);
    return pkt_cnt[k*CNT_W +: CNT_W];
  endfunction

  initial begin
    int hi_cnt;
    int run;

    rst = 1'b1; cnt_clr = 1'b0; m_ready = 4'hF;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    step();
    chk_en = 1'b1;
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_in_pkt", 32'(in_pkt), 32'h0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'h1);

    // Single-beat packets to each port.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'(8'h10 + k), 1'b1);
      step();
      chk("t1_valid", 32'(m_valid[k]), 32'h1);
      chk("t1_data", 32'(port_data(k)), 32'(8'h10 + k));
      chk("t1_in_pkt", 32'(in_pkt), 32'h0);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    for (int k = 0; k < 4; k++) chk("t1_cnt", 32'(port_cnt(k)), 32'h1);

    // Packet lock: s_sel changes after the first beat must be ignored.
    clear_counts();
    hi_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, (b == 0) ? 2'd2 : 2'd1, 8'(8'h20 + b), b == 3);
      step();
      chk("t2_port2", 32'(m_valid[2]), 32'h1);
      chk("t2_port1", 32'(m_valid[1]), 32'h0);
      chk("t2_data", 32'(port_data(2)), 32'(8'h20 + b));
      if (in_pkt) hi_cnt++;
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("t2_in_pkt_cycles", 32'(hi_cnt), 32'd3);
    chk("t2_cnt2", 32'(port_cnt(2)), 32'h1);

    // Backpressure isolation on port 1.
    m_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'hA1, 1'b1);
    step();
    drive(1'b1, 2'd1, 8'hB1, 1'b1);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t3_stall", 32'(s_ready), 32'h0);
      step();
      chk("t3_hold", 32'(port_data(1)), 32'hA1);
    end
    m_ready = 4'hF;
    #1;
    chk("t3_release", 32'(s_ready), 32'h1);
    step();
    chk("t3_second", 32'(port_data(1)), 32'hB1);
    drive(1'b1, 2'd3, 8'hC3, 1'b1);
    step();
    chk("t3_port3", 32'(port_data(3)), 32'hC3);
    chk("t3_port3_valid", 32'(m_valid[3]), 32'h1);

    // Continuous 8-beat stream to port 0: no bubbles.
    run = 0;
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, 2'd0, 8'(8'h40 + b), b == 7);
      step();
      if (m_valid[0]) run++;
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("t4_run", 32'(run), 32'd8);
    chk("t4_empty", 32'(m_valid[0]), 32'h0);

    // Counter saturation and clear precedence.
    clear_counts();
    for (int p = 0; p < 17; p++) begin
      drive(1'b1, 2'd3, 8'(p), 1'b1);
      step();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("t5_sat", 32'(port_cnt(3)), 32'd15);
    drive(1'b1, 2'd3, 8'h55, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t5_clr", 32'(port_cnt(3)), 32'd0);

    // Reset in the middle of a packet to port 1.
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, 2'd1, 8'(8'h60 + b), 1'b0);
      step();
    end
    drive(1'b0, 2'd1, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", 32'(m_valid), 32'h0);
    chk("t6_in_pkt", 32'(in_pkt), 32'h0);
    drive(1'b1, 2'd0, 8'h77, 1'b1);
    #1;
    chk("t6_ready", 32'(s_ready), 32'h1);
    step();
    chk("t6_port0", 32'(port_data(0)), 32'h77);
    chk("t6_port0_valid", 32'(m_valid[0]), 32'h1);
    chk("t6_port1_valid", 32'(m_valid[1]), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            8'($urandom), ($urandom_range(0, 2) == 0));
      m_ready = 4'($urandom);
      cnt_clr = ($urandom_range(0, 199) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
